// File: rtl/div_round_sat_buffer.sv
// Post-divider stage: tracks issue validity alongside the divider pipeline,
// rounds each quotient half away from zero, saturates it to OUT_W bits and
// queues it with its cb/cr side-band in a first-word-fall-through FIFO.
// A credit check keeps results from being lost under output backpressure.
module div_round_sat_buffer #(
    parameter int unsigned LATENCY = 36,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_neg,
    input  logic             issue_div0,
    input  logic [34:0]      issue_dmag,
    input  logic [34:0]      quotient,
    input  logic [34:0]      reminder,
    input  logic [34:0]      in_cb,
    input  logic [34:0]      in_cr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_q,
    output logic [34:0]      out_cb,
    output logic [34:0]      out_cr,
    output logic             out_sat,
    output logic             out_div0,
    output logic             overflow
);

    localparam int unsigned DW    = 35;
    localparam int unsigned AW    = DW + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    // Every issue leaves the delay line and round stage within LATENCY+1 edges,
    // so inflight can never exceed LATENCY+1 even under protocol violations.
    localparam int unsigned INF_W = $clog2(LATENCY + 2);
    localparam int unsigned SUM_W = INF_W + CNT_W;

    localparam logic signed [AW-1:0] Q_MAX = AW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [AW-1:0] Q_MIN = ~Q_MAX;

    typedef struct packed {
        logic          valid;
        logic          neg;
        logic          div0;
        logic [DW-1:0] dmag;
    } tag_t;

    typedef struct packed {
        logic [OUT_W-1:0] q;
        logic [DW-1:0]    cb;
        logic [DW-1:0]    cr;
        logic             sat;
        logic             div0;
    } entry_t;

    tag_t                    dly [LATENCY];
    tag_t                    tap;

    logic                    rnd_up;
    logic signed [AW-1:0]    q_ext;
    logic signed [AW-1:0]    step;
    logic signed [AW-1:0]    q_rnd;
    entry_t                  rnd_d;

    logic                    rnd_valid;
    entry_t                  rnd_q;

    entry_t                  mem [DEPTH];
    entry_t                  head;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic                    full;
    logic                    rd_en;
    logic                    wr_en;
    logic                    drop;

    logic [INF_W-1:0]        inflight;

    assign tap = dly[LATENCY-1];

    // Delay line carrying issue validity and rounding context beside the divider
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= '{valid: issue_valid, neg: issue_neg, div0: issue_div0, dmag: issue_dmag};
            for (int i = 1; i < int'(LATENCY); i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Round half away from zero, then clip to the signed OUT_W range
    always_comb begin
        rnd_up = {reminder, 1'b0} >= {1'b0, tap.dmag};
        q_ext  = {quotient[DW-1], quotient};
        step   = '0;
        if (rnd_up) begin
            step = tap.neg ? '1 : AW'(1);
        end
        q_rnd    = q_ext + step;
        rnd_d    = '0;
        rnd_d.cb = in_cb;
        rnd_d.cr = in_cr;
        if (tap.div0) begin
            rnd_d.q    = tap.neg ? Q_MIN[OUT_W-1:0] : Q_MAX[OUT_W-1:0];
            rnd_d.div0 = 1'b1;
        end else if (q_rnd > Q_MAX) begin
            rnd_d.q   = Q_MAX[OUT_W-1:0];
            rnd_d.sat = 1'b1;
        end else if (q_rnd < Q_MIN) begin
            rnd_d.q   = Q_MIN[OUT_W-1:0];
            rnd_d.sat = 1'b1;
        end else begin
            rnd_d.q = q_rnd[OUT_W-1:0];
        end
    end

    // Round stage register, loaded only when the aligned tap is valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            rnd_valid <= 1'b0;
            rnd_q     <= '0;
        end else begin
            rnd_valid <= tap.valid;
            if (tap.valid) begin
                rnd_q <= rnd_d;
            end
        end
    end

    assign full  = (fifo_count == CNT_W'(DEPTH));
    assign rd_en = out_valid && out_ready;
    assign wr_en = rnd_valid && (!full || rd_en);
    assign drop  = rnd_valid && full && !rd_en;

    // FIFO storage; contents are don't-care until the count says otherwise
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= rnd_q;
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Results still travelling through the divider and round stage
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + INF_W'(issue_valid) - INF_W'(rnd_valid);
        end
    end

    assign issue_ready = (SUM_W'(inflight) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);

    // Fall-through head; forced to zero while the FIFO is empty
    assign out_valid = (fifo_count != '0);
    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_q     = head.q;
    assign out_cb    = head.cb;
    assign out_cr    = head.cr;
    assign out_sat   = head.sat;
    assign out_div0  = head.div0;

endmodule

// File: tb/tb_div_round_sat_buffer.sv
// Directed bench for div_round_sat_buffer with a stand-in divider delay line.
module tb_div_round_sat_buffer;

    localparam int unsigned LATENCY = 36;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned DEPTH   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic             issue_neg;
    logic             issue_div0;
    logic [34:0]      issue_dmag;
    logic [34:0]      quotient;
    logic [34:0]      reminder;
    logic [34:0]      in_cb;
    logic [34:0]      in_cr;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_q;
    logic [34:0]      out_cb;
    logic [34:0]      out_cr;
    logic             out_sat;
    logic             out_div0;
    logic             overflow;

    logic [34:0]      res_q;
    logic [34:0]      res_r;
    logic [34:0]      res_cb;
    logic [34:0]      res_cr;
    logic [139:0]     pipe [LATENCY];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_round_sat_buffer #(
        .LATENCY(LATENCY),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_neg  (issue_neg),
        .issue_div0 (issue_div0),
        .issue_dmag (issue_dmag),
        .quotient   (quotient),
        .reminder   (reminder),
        .in_cb      (in_cb),
        .in_cr      (in_cr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_cb     (out_cb),
        .out_cr     (out_cr),
        .out_sat    (out_sat),
        .out_div0   (out_div0),
        .overflow   (overflow)
    );

    // Divider stand-in: results appear LATENCY edges after they are issued
    always @(posedge clk) begin
        for (int i = LATENCY - 1; i > 0; i--) begin
            pipe[i] <= pipe[i-1];
        end
        pipe[0] <= {res_q, res_r, res_cb, res_cr};
    end
    assign {quotient, reminder, in_cb, in_cr} = pipe[LATENCY-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic neg, input logic div0, input logic [34:0] dmag,
                               input logic [34:0] q, input logic [34:0] r);
        issue_valid = 1'b1;
        issue_neg   = neg;
        issue_div0  = div0;
        issue_dmag  = dmag;
        res_q       = q;
        res_r       = r;
        res_cb      = 35'h11;
        res_cr      = 35'h22;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic neg, input logic div0,
                           input logic [34:0] dmag, input logic [34:0] q, input logic [34:0] r,
                           input logic [15:0] eq, input logic esat, input logic ediv0);
        int lat;
        lat = 0;
        drive_issue(neg, div0, dmag, q, r);
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"},  64'(lat),      64'd37);
        check({tag, "_q"},    64'(out_q),    64'(eq));
        check({tag, "_sat"},  64'(out_sat),  64'(esat));
        check({tag, "_div0"}, 64'(out_div0), 64'(ediv0));
        check({tag, "_cb"},   64'(out_cb),   64'h11);
        check({tag, "_cr"},   64'(out_cr),   64'h22);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_empty"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int n;
        int seen;
        rst         = 1'b0;
        issue_valid = 1'b0;
        issue_neg   = 1'b0;
        issue_div0  = 1'b0;
        issue_dmag  = '0;
        res_q       = '0;
        res_r       = '0;
        res_cb      = '0;
        res_cr      = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        check("rst_valid",    64'(out_valid),   64'd0);
        check("rst_q",        64'(out_q),       64'd0);
        check("rst_cb",       64'(out_cb),      64'd0);
        check("rst_cr",       64'(out_cr),      64'd0);
        check("rst_sat",      64'(out_sat),     64'd0);
        check("rst_div0",     64'(out_div0),    64'd0);
        check("rst_overflow", 64'(overflow),    64'd0);
        check("rst_ready",    64'(issue_ready), 64'd1);

        // Rounding, saturation and divide-by-zero vectors
        run_one("rdown",   1'b0, 1'b0, 35'd8 - 35'd1, 35'd14,        35'd2, 16'd14,     1'b0, 1'b0);
        run_one("hpos",    1'b0, 1'b0, 35'd8,         35'd12,        35'd4, 16'd13,     1'b0, 1'b0);
        run_one("hneg",    1'b1, 1'b0, 35'd8,         35'(-12),      35'd4, 16'(-13),   1'b0, 1'b0);
        run_one("satp",    1'b0, 1'b0, 35'd1,         35'd1000000,   35'd0, 16'd32767,  1'b1, 1'b0);
        run_one("satn",    1'b1, 1'b0, 35'd1,         35'(-1000000), 35'd0, 16'h8000,   1'b1, 1'b0);
        run_one("d0pos",   1'b0, 1'b1, 35'd0,         35'h7ffffffff, 35'd5, 16'd32767,  1'b0, 1'b1);
        run_one("d0neg",   1'b1, 1'b1, 35'd0,         35'd0,         35'd5, 16'h8000,   1'b0, 1'b1);
        run_one("edgemax", 1'b0, 1'b0, 35'd2,         35'd32766,     35'd1, 16'd32767,  1'b0, 1'b0);
        run_one("edgeovf", 1'b0, 1'b0, 35'd2,         35'd32767,     35'd1, 16'd32767,  1'b1, 1'b0);
        run_one("edgemin", 1'b1, 1'b0, 35'd5,         35'(-32767),   35'd3, 16'h8000,   1'b0, 1'b0);

        // Back-to-back issues come out one per cycle in order
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_issue(1'b0, 1'b0, 35'd1, 35'(i + 1), 35'd0);
        end
        for (int i = 0; i < 60; i++) begin
            if (out_valid) break;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_q",     64'(out_q),     64'(i + 1));
            tick();
        end
        check("b2b_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Backpressure: credits limit issues to DEPTH
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (issue_ready) begin
                issue_valid = 1'b1;
                issue_neg   = 1'b0;
                issue_div0  = 1'b0;
                issue_dmag  = 35'd1;
                res_q       = 35'(100 + n);
                res_r       = 35'd0;
                n++;
            end else begin
                issue_valid = 1'b0;
            end
            tick();
        end
        issue_valid = 1'b0;
        check("bp_issued", 64'(n),           64'd8);
        check("bp_ready0", 64'(issue_ready), 64'd0);
        for (int i = 0; i < 45; i++) tick();
        check("bp_full_valid", 64'(out_valid),   64'd1);
        check("bp_full_ready", 64'(issue_ready), 64'd0);
        check("bp_overflow",   64'(overflow),    64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_drain_valid", 64'(out_valid), 64'd1);
            check("bp_drain_q",     64'(out_q),     64'(100 + i));
            tick();
        end
        out_ready = 1'b0;
        check("bp_drained", 64'(out_valid),   64'd0);
        check("bp_ready1",  64'(issue_ready), 64'd1);

        // Reset mid-flight discards pending results
        for (int i = 0; i < 3; i++) begin
            drive_issue(1'b0, 1'b0, 35'd1, 35'd7, 35'd0);
        end
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_valid",    64'(seen),        64'd0);
        check("mid_rst_ready",    64'(issue_ready), 64'd1);
        check("mid_rst_overflow", 64'(overflow),    64'd0);

        // Ignoring credits drops the ninth result and sets sticky overflow
        for (int i = 0; i < 9; i++) begin
            drive_issue(1'b0, 1'b0, 35'd1, 35'(200 + i), 35'd0);
        end
        for (int i = 0; i < 45; i++) tick();
        check("ovf_set",   64'(overflow),  64'd1);
        check("ovf_head",  64'(out_q),     64'd200);
        check("ovf_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("ovf_clear",       64'(overflow),    64'd0);
        check("ovf_clear_valid", 64'(out_valid),   64'd0);
        check("ovf_clear_ready", 64'(issue_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_round_sat_buffer.md
# div_round_sat_buffer

Post-processing stage placed directly downstream of the 36-stage pipelined 35-bit signed divider. The divider has no valid or stall signal, so this block tracks issue validity through a matching delay line. It rounds each quotient to nearest, saturates it to an output width, and buffers the result with its cb/cr side-band in a small FIFO. It also gives upstream a credit signal so no result is lost under output backpressure.

## Interface
- LATENCY, 36, divider pipeline depth (issue edge to quotient visible)
- OUT_W, 16, signed result width
- DEPTH, 8, FIFO entries and credit limit (power of two)
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- issue_valid  in  1  divider inputs presented this cycle
- issue_ready  out  1  issuing allowed this cycle
- issue_neg  in  1  dividend[34]^divisor[34] of the issued pair
- issue_div0  in  1  issued divisor equals 0
- issue_dmag  in  35  |divisor| of the issued pair
- quotient  in  35  signed quotient from divider
- reminder  in  35  remainder magnitude from divider
- in_cb, in_cr  in  35 each  divider out_cb/out_cr
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_q  out  OUT_W  rounded, saturated quotient
- out_cb, out_cr  out  35 each  side-band aligned with out_q
- out_sat  out  1  result was clipped
- out_div0  out  1  result came from a divide by zero
- overflow  out  1  sticky: a result was dropped because the FIFO was full

## Operation
- **Delay line.** LATENCY-stage shift register carries {valid, neg, div0, dmag}. Stage 1 loads at the same edge the divider samples its inputs. Stage LATENCY is aligned with the quotient/reminder/in_cb/in_cr currently on the divider outputs.
- **Round stage.** One register, loaded from the stage-LATENCY tap when that tap's valid is 1. All arithmetic is 36 bits, sign-extended.
  - rnd = ({reminder,1'b0} >= {1'b0,dmag}).
  - qr = quotient + (rnd ? (neg ? -1 : +1) : 0), i.e. round half away from zero.
  - qr > 2^(OUT_W-1)-1 gives max and sat=1; qr < -2^(OUT_W-1) gives min and sat=1.
  - div0=1 bypasses rounding: result = neg ? min : max, sat=0, div0=1.
- **FIFO.** First-word-fall-through, DEPTH entries of {q, cb, cr, sat, div0}.
  - Write: round-stage valid and not full.
  - Read: out_valid && out_ready.
  - Simultaneous read and write while full is allowed; count is unchanged.
  - Write while full and no read: drop the entry and set overflow. overflow clears only on reset.
- **Credits.** inflight counter is incremented on issue_valid and decremented when a round-stage entry is written to (or dropped from) the FIFO.
  - issue_ready = (inflight + fifo_count) < DEPTH; combinational from registers only.
  - issue_valid while issue_ready=0 is still tracked. It is a protocol violation and may set overflow.
- **Reset.** While rst=0 at an edge: the delay line, round stage and FIFO are cleared, inflight=0 and overflow=0.
  - Outputs after reset: out_valid=0, out_q=0, out_cb=0, out_cr=0, out_sat=0, out_div0=0, overflow=0, issue_ready=1.
  - Reset mid-flight discards all pending results. Divider outputs arriving later are ignored because the delay-line valids are 0.

## Timing
- Issue sampled at edge k.
  - Delay tap valid after edge k+LATENCY-1.
  - Round register loads at edge k+LATENCY.
  - FIFO write at edge k+LATENCY+1.
  - With the FIFO empty, out_valid=1 from edge k+37 (LATENCY=36).
- Back-to-back issues produce back-to-back outputs at one per cycle when out_ready=1.
- Output order equals issue order.
- out_* are stable while out_valid=1 and out_ready=0.
- issue_ready reflects the state after the previous edge. An issue at edge k lowers issue_ready from edge k if it consumed the last credit.

## Test plan
- **Round down.** 100/7 issued (q=14, r=2, dmag=7) → out_q=14, sat=0, div0=0, out_valid 37 edges after issue.
- **Half rounding.** 100/8 → 13; -100/8 (q=-12, r=4, neg=1) → -13; cb=0x11, cr=0x22 appear unchanged with each result.
- **Saturation.** 1000000/1 → 32767, sat=1; -1000000/1 → -32768, sat=1.
- **Divide by zero.** 5/0 (div0=1, neg=0) → 32767, div0=1, sat=0; -5/0 (neg=1) → -32768, div0=1.
- **Backpressure.** out_ready=0, issue_valid held high while issue_ready=1 → exactly 8 issues accepted; issue_ready=0 afterwards; the FIFO fills with 8 in-order results and overflow stays 0. Raising out_ready drains 8 results in 8 cycles and issue_ready returns to 1.
- **Reset mid-flight.** 3 issues, then rst=0 for one edge 10 cycles later → no out_valid for 60 cycles; issue_ready=1; overflow=0.
